// File: rtl/load_use_hazard_ctrl.sv
// ============================================================================
// load_use_hazard_ctrl
// ----------------------------------------------------------------------------
// Load-use hazard and branch-flush controller that sits at the EXE end of the
// ID/EXE pipeline register of a classic 5-stage MIPS-style pipeline.
//
// The EXE-stage copy of MemRead and rt (the load destination, as latched in
// ID/EXE) is compared against the source registers of the instruction
// currently in ID. On a dependency, PC and IF/ID are frozen and bubbles are
// injected into ID/EXE for LOAD_LAT cycles. A branch/jump resolved taken in
// ID flushes IF/ID, unless a stall is being raised in the same cycle.
//
// Parameters:
//   LOAD_LAT  data-memory load latency = bubble cycles per hazard (1..15)
//   CNT_W     width of each performance counter
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous reset, active-low (0 = reset)
//   id_rs          in   [4:0] rs field of the ID instruction
//   id_rt          in   [4:0] rt field of the ID instruction
//   id_uses_rs     in   ID instruction reads rs
//   id_uses_rt     in   ID instruction reads rt
//   exe_mem_read   in   MemRead held in ID/EXE
//   exe_rt         in   [4:0] load destination held in ID/EXE
//   branch_taken   in   branch/jump resolved taken in ID this cycle
//   pc_write       out  PC update enable
//   if_id_write    out  IF/ID write enable
//   if_id_flush    out  clear IF/ID to NOP on the next edge
//   id_exe_bubble  out  zero the ID/EXE control fields on the next edge
//   hz_state       out  [1:0] FSM state (debug)
//   stall_cnt      out  [CNT_W-1:0] total stall cycles (saturating)
//   flush_cnt      out  [CNT_W-1:0] total IF/ID flushes (saturating)
//
// Build option:
//   HAZARD_PERF_CNT_EN  when defined, stall_cnt / flush_cnt are real
//                       saturating counters; otherwise both are tied to 0.
// ============================================================================
module load_use_hazard_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             exe_mem_read,
    input  logic [4:0]       exe_rt,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_exe_bubble,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01
    } state_t;

    // The first stall cycle is spent in RUN (the cycle hz is detected), so
    // STALL covers the remaining LOAD_LAT-1 cycles: wait_cnt counts down
    // from LOAD_LAT-2 to 0 inclusive.
    localparam logic [3:0] STALL_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;
    localparam bit         USE_STALL  = (LOAD_LAT > 1);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] wait_cnt_reg;
    logic [3:0] wait_cnt_next;

    logic       hz;
    logic       src_rs_match;
    logic       src_rt_match;

    // ------------------------------------------------------------------
    // Hazard detection. $0 is hard-wired zero, so a load "into" it can
    // never create a real dependency.
    // ------------------------------------------------------------------
    assign src_rs_match = id_uses_rs && (id_rs == exe_rt);
    assign src_rt_match = id_uses_rt && (id_rt == exe_rt);
    assign hz = exe_mem_read && (exe_rt != 5'd0) && (src_rs_match || src_rt_match);

    // ------------------------------------------------------------------
    // Pipeline control outputs: combinational from state and inputs so the
    // stall takes effect in the very cycle the dependency is seen.
    // ------------------------------------------------------------------
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_exe_bubble = 1'b0;
        if (!rst) begin
            // Hold the front end and drain both pipeline registers to NOPs.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
        end else if (state_reg == STALL) begin
            // Stall in progress: hz and branch_taken are both ignored.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_bubble = 1'b1;
        end else if (hz) begin
            // Stall beats a simultaneous taken branch; the branch sits in ID
            // and resolves again once the stall is over.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_bubble = 1'b1;
        end else begin
            // RUN (and the illegal encodings, which behave as RUN).
            if_id_flush   = branch_taken;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            RUN: begin
                // With LOAD_LAT==1 the bubble itself moves the load out of
                // EXE, so hz drops next cycle without any extra state.
                if (hz && USE_STALL) begin
                    state_next    = STALL;
                    wait_cnt_next = STALL_INIT;
                end
            end
            STALL: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = RUN;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            default: begin
                // Unreachable encodings recover to RUN on the next edge.
                state_next    = RUN;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Debug view of the FSM; shows RUN while reset is held so a stall that
    // was aborted by reset is not reported.
    assign hz_state = rst ? state_reg : RUN;

    // ------------------------------------------------------------------
    // Optional saturating performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            // Counters stick at all-ones instead of wrapping.
            if (!pc_write && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (if_id_flush && (flush_cnt_reg != {CNT_W{1'b1}})) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_load_use_hazard_ctrl.sv
// Scoreboard bench: three DUTs (LOAD_LAT = 1, 3, 4) share the same stimulus.
// The stimulus process computes the expected outputs of every DUT from a
// "remaining stall cycles" model and pushes them into a queue; the monitor
// pops one entry per cycle at the falling edge and compares.
module tb_load_use_hazard_ctrl;

    localparam int NDUT = 3;
    localparam int CW   = 32;

    logic clk;
    logic rst;
    logic [4:0] id_rs, id_rt, exe_rt;
    logic id_uses_rs, id_uses_rt, exe_mem_read, branch_taken;

    logic [NDUT-1:0] pcw, ifw, flu, bub;
    logic [1:0]    hzs [NDUT];
    logic [CW-1:0] sc  [NDUT];
    logic [CW-1:0] fc  [NDUT];

    load_use_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(CW)) u_dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .exe_mem_read(exe_mem_read), .exe_rt(exe_rt), .branch_taken(branch_taken),
        .pc_write(pcw[0]), .if_id_write(ifw[0]), .if_id_flush(flu[0]),
        .id_exe_bubble(bub[0]), .hz_state(hzs[0]), .stall_cnt(sc[0]), .flush_cnt(fc[0]));

    load_use_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(CW)) u_dut3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .exe_mem_read(exe_mem_read), .exe_rt(exe_rt), .branch_taken(branch_taken),
        .pc_write(pcw[1]), .if_id_write(ifw[1]), .if_id_flush(flu[1]),
        .id_exe_bubble(bub[1]), .hz_state(hzs[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1]));

    load_use_hazard_ctrl #(.LOAD_LAT(4), .CNT_W(CW)) u_dut4 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .exe_mem_read(exe_mem_read), .exe_rt(exe_rt), .branch_taken(branch_taken),
        .pc_write(pcw[2]), .if_id_write(ifw[2]), .if_id_flush(flu[2]),
        .id_exe_bubble(bub[2]), .hz_state(hzs[2]), .stall_cnt(sc[2]), .flush_cnt(fc[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          cyc;
        logic [NDUT-1:0] pcw, ifw, flu, bub;
        logic [1:0]  hzs [NDUT];
        logic [CW-1:0] sc [NDUT];
        logic [CW-1:0] fc [NDUT];
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit stim_done = 1'b0;

    // ---------------- reference model state ----------------
    int      lat      [NDUT] = '{1, 3, 4};
    int      rem      [NDUT];   // stall cycles still owed after this one
    int      rem_next [NDUT];
    longint  m_sc     [NDUT];
    longint  m_fc     [NDUT];
    bit      prev_rst;
    bit      prev_stall [NDUT];
    bit      prev_flush [NDUT];

    localparam longint CMAX = (64'd1 << CW) - 1;

    // Apply one clock edge to the model, then drive the next cycle's inputs
    // and push the expected outputs of that cycle.
    task automatic drive(input bit r, input int rs, input int rt, input bit urs,
                         input bit urt, input bit mr, input int ert, input bit bt);
        exp_t e;
        bit   dep;
        @(posedge clk);
        #1;
        cycle++;
        for (int k = 0; k < NDUT; k++) begin
            if (!prev_rst) begin
                rem[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            end else begin
                rem[k] = rem_next[k];
                if (prev_stall[k] && m_sc[k] < CMAX) m_sc[k]++;
                if (prev_flush[k] && m_fc[k] < CMAX) m_fc[k]++;
            end
        end
        rst = r; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
        exe_mem_read = mr; exe_rt = 5'(ert); branch_taken = bt;

        // A dependency exists if a load targets a non-zero register that the
        // ID instruction actually reads.
        dep = mr && (ert != 0) && ((urs && rs == ert) || (urt && rt == ert));

        e.cyc = cycle;
        for (int k = 0; k < NDUT; k++) begin
            bit stall, fl;
            stall = 1'b0; fl = 1'b0;
            if (!r) begin
                e.hzs[k] = 2'b00;
                rem_next[k] = 0;
                stall = 1'b1; fl = 1'b1;
            end else if (rem[k] > 0) begin
                e.hzs[k] = 2'b01;
                stall = 1'b1;
                rem_next[k] = rem[k] - 1;
            end else begin
                e.hzs[k] = 2'b00;
                if (dep) begin
                    stall = 1'b1;
                    rem_next[k] = lat[k] - 1;
                end else begin
                    fl = bt;
                    rem_next[k] = 0;
                end
            end
            e.pcw[k] = !stall;
            e.ifw[k] = !stall;
            e.bub[k] = stall;
            e.flu[k] = fl;
`ifdef HAZARD_PERF_CNT_EN
            e.sc[k] = CW'(m_sc[k]);
            e.fc[k] = CW'(m_fc[k]);
`else
            e.sc[k] = '0;
            e.fc[k] = '0;
`endif
            prev_stall[k] = r && stall;
            prev_flush[k] = r && fl;
        end
        prev_rst = r;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int k, input int cyc,
                       input logic [CW-1:0] act, input logic [CW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL cyc=%0d dut%0d %s: got %0h expected %0h", cyc, lat[k], name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int k = 0; k < NDUT; k++) begin
                    chk("pc_write",      k, e.cyc, CW'(pcw[k]), CW'(e.pcw[k]));
                    chk("if_id_write",   k, e.cyc, CW'(ifw[k]), CW'(e.ifw[k]));
                    chk("if_id_flush",   k, e.cyc, CW'(flu[k]), CW'(e.flu[k]));
                    chk("id_exe_bubble", k, e.cyc, CW'(bub[k]), CW'(e.bub[k]));
                    chk("hz_state",      k, e.cyc, CW'(hzs[k]), CW'(e.hzs[k]));
                    chk("stall_cnt",     k, e.cyc, sc[k], e.sc[k]);
                    chk("flush_cnt",     k, e.cyc, fc[k], e.fc[k]);
                end
                $display("cyc=%0d rst=%0b hz_in mr=%0b ert=%0d rs=%0d/%0b rt=%0d/%0b bt=%0b -> pcw=%b flush=%b hzs=%0d/%0d/%0d",
                         e.cyc, rst, exe_mem_read, exe_rt, id_rs, id_uses_rs, id_rt, id_uses_rt,
                         branch_taken, pcw, flu, hzs[0], hzs[1], hzs[2]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wait_cyc;
        rst = 1'b0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        exe_mem_read = 0; exe_rt = 0; branch_taken = 0;
        prev_rst = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            rem[k] = 0; rem_next[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            prev_stall[k] = 0; prev_flush[k] = 0;
        end

        //     rst rs rt urs urt mr ert bt
        drive(0, 0, 0, 0, 0, 0, 0, 0);   // reset: forced outputs
        drive(0, 5, 0, 1, 0, 1, 5, 1);   // reset masks hazard and branch
        // Hazard on rs, then load leaves EXE
        drive(1, 5, 0, 1, 0, 1, 5, 0);
        drive(1, 5, 0, 1, 0, 0, 0, 0);
        drive(1, 5, 0, 1, 0, 0, 0, 0);
        drive(1, 5, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        // Hazard on rt, single detection cycle
        drive(1, 0, 5, 0, 1, 1, 5, 0);
        for (int i = 0; i < 4; i++) drive(1, 0, 5, 0, 1, 0, 0, 0);
        // $0 never hazards; unused rt never hazards
        drive(1, 0, 0, 1, 1, 1, 0, 0);
        drive(1, 0, 5, 0, 0, 1, 5, 0);
        // Plain taken branch for one cycle
        drive(1, 1, 2, 1, 1, 0, 0, 1);
        drive(1, 1, 2, 1, 1, 0, 0, 0);
        // Hazard + branch together, then branch without hazard
        drive(1, 7, 0, 1, 0, 1, 7, 1);
        drive(1, 7, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive(1, 7, 0, 1, 0, 0, 0, 0);
        // Reset during the second STALL cycle of the LOAD_LAT=4 instance
        drive(1, 3, 0, 1, 0, 1, 3, 0);
        drive(1, 3, 0, 1, 0, 0, 0, 0);
        drive(0, 3, 0, 1, 0, 0, 0, 0);
        drive(0, 3, 0, 1, 0, 0, 0, 0);
        drive(1, 3, 0, 1, 0, 0, 0, 0);
        // Back-to-back loads feeding the held ID instruction
        drive(1, 4, 0, 1, 0, 1, 4, 1);
        for (int i = 0; i < 5; i++) drive(1, 4, 0, 1, 0, 1, 4, 0);

        // Randomised traffic with small register numbers to hit matches often
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 39) != 0),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0));
        end
        stim_done = 1'b1;

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_use_hazard_ctrl.md
Name: load_use_hazard_ctrl

Overview:
- Hazard controller at the EXE end of the ID/EXE pipeline register.
- Reads the EXE-stage copy of the load control and destination (MemRead and rt as latched in ID/EXE) and compares it against the source registers of the instruction currently in ID.
- On a load-use dependency it freezes PC and IF/ID and injects bubbles into ID/EXE for the data-memory latency; on a taken branch it flushes IF/ID.
- Optional saturating performance counters are included.

Parameters:
- LOAD_LAT, 1: data-memory load latency in cycles, i.e. the number of bubble cycles per load-use hazard. Legal range 1..15.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- id_rs  input  5  rs field, instruction[25:21], of the instruction in ID.
- id_rt  input  5  rt field, instruction[20:16], of the instruction in ID.
- id_uses_rs  input  1  the ID instruction reads rs.
- id_uses_rt  input  1  the ID instruction reads rt (R-type, store, beq/bne).
- exe_mem_read  input  1  MemRead control held in ID/EXE (EXE stage).
- exe_rt  input  5  rt (load destination) held in ID/EXE.
- branch_taken  input  1  branch/jump resolved taken in ID this cycle.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID register write enable.
- if_id_flush  output  1  clear IF/ID to NOP on the next edge.
- id_exe_bubble  output  1  force ID/EXE control fields to zero on the next edge.
- hz_state  output  2  FSM state, for debug.
- stall_cnt  output  CNT_W  total stall cycles.
- flush_cnt  output  CNT_W  total IF/ID flushes.

Behaviour:
- Hazard term: hz = exe_mem_read & exe_rt!=0 & ((id_uses_rs & id_rs==exe_rt) | (id_uses_rt & id_rt==exe_rt)). Register $0 never causes a hazard.
- FSM states: RUN=2'b00, STALL=2'b01. Encodings 2'b10 and 2'b11 are illegal and return to RUN on the next edge; outputs in those states follow the RUN equations.
- Down-counter wait_cnt is 4 bits wide.
- RUN, hz=1:
  - pc_write=0, if_id_write=0, id_exe_bubble=1, if_id_flush=0 in the same cycle (combinational).
  - If LOAD_LAT>1: next state STALL, wait_cnt<=LOAD_LAT-2.
  - If LOAD_LAT==1: stay in RUN. The bubble moves the load out of EXE, so hz clears next cycle, giving exactly one stall cycle.
- RUN, hz=0:
  - pc_write=1, if_id_write=1, id_exe_bubble=0.
  - if_id_flush=branch_taken.
- STALL:
  - pc_write=0, if_id_write=0, id_exe_bubble=1, if_id_flush=0.
  - If wait_cnt==0: next state RUN. Otherwise wait_cnt decrements.
  - hz is not evaluated in STALL.
- Total stall per hazard is exactly LOAD_LAT cycles. The ID instruction is re-evaluated in RUN afterwards, so a back-to-back dependency on a second load stalls again.
- Simultaneous hz and branch_taken: the stall wins and if_id_flush=0. The held branch re-resolves after the stall.
- branch_taken is ignored in STALL.
- Reset (rst==0 sampled at a rising edge):
  - state<=RUN, wait_cnt<=0, stall_cnt<=0, flush_cnt<=0.
  - While rst==0, outputs are forced to pc_write=0, if_id_write=0, if_id_flush=1, id_exe_bubble=1, hz_state=RUN.
  - Reset in the middle of STALL aborts the stall. After reset releases, the first edge behaves as RUN.
- All outputs except the counters and hz_state are combinational from state and inputs. There is no added latency.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every edge where pc_write==0 and rst==1.
  - flush_cnt increments on every edge where if_id_flush==1 and rst==1.
  - Both counters saturate at all-ones and never wrap.
- Undefined: the counters are not synthesized and stall_cnt and flush_cnt are tied to 0.

Test Plan:
1. LOAD_LAT=1, exe_mem_read=1, exe_rt=5, id_rs=5, id_uses_rs=1 -> exactly 1 cycle with pc_write=0, if_id_write=0, id_exe_bubble=1. Next cycle, with exe_mem_read=0, pc_write=1. stall_cnt=1.
2. LOAD_LAT=3, same hazard on id_rt=5 with id_uses_rt=1 -> 3 consecutive stall cycles; hz_state goes 00,01,01,00. stall_cnt=3.
3. exe_mem_read=1, exe_rt=0, id_rs=0 -> no stall, pc_write=1. Also exe_rt=5, id_rt=5, id_uses_rt=0 -> no stall.
4. No hazard, branch_taken=1 for one cycle -> if_id_flush=1 for that cycle only. flush_cnt=1.
5. hz and branch_taken asserted together (LOAD_LAT=1) -> if_id_flush=0 and stall. The next cycle has branch_taken=1 and no hz -> if_id_flush=1.
6. LOAD_LAT=4: drive rst=0 during the second STALL cycle -> state=RUN, counters 0, reset output values held. After release with no hazard, pc_write=1. Rebuild without HAZARD_PERF_CNT_EN -> stall_cnt and flush_cnt stay 0 throughout.
